// File: rtl/eth_types_pkg.sv
// Shared Ethernet types and constants for the transmit path.
package eth_types_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FORWARD,
        PAD,
        DRAIN,
        IFG
    } tx_sched_states;

    localparam int unsigned ETH_MIN_FRAME_LEN = 60;
    localparam int unsigned ETH_MAX_FRAME_LEN = 1514;
    localparam int unsigned ETH_IFG_BYTES     = 12;

    // Increment modulo n, used to advance round-robin pointers.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_id    = idx;
            end
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Round-robin scheduler sharing one MAC TX byte stream between NUM_REQ frame sources,
// with minimum-length zero padding, MAX_LEN truncation and an inter-frame gap.
module eth_tx_scheduler
    import eth_types_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MIN_LEN    = ETH_MIN_FRAME_LEN,
    parameter int unsigned MAX_LEN    = ETH_MAX_FRAME_LEN,
    parameter int unsigned IFG_CYCLES = ETH_IFG_BYTES,
    localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0][7:0] req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_last,
    input  logic                    tx_ready,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    err_trunc
);

    localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [11:0] MIN_C = 12'(MIN_LEN);
    localparam logic [11:0] MAX_C = 12'(MAX_LEN);

    tx_sched_states  state_q, state_d;
    logic [ID_W-1:0] ptr_q;
    logic [10:0]     byte_cnt_q;
    logic [IFG_W-1:0] ifg_cnt_q;

    logic [ID_W-1:0] arb_id;
    logic            arb_valid;
    logic            cur_valid, cur_last;
    logic [7:0]      cur_data;
    logic [11:0]     cnt_inc;
    logic            at_min, at_max, tx_xfer, ifg_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .gnt_id    (arb_id),
        .gnt_valid (arb_valid)
    );

    assign cur_valid = req_valid[grant_id];
    assign cur_last  = req_last[grant_id];
    assign cur_data  = req_data[grant_id];
    // cnt_inc is the 1-based number of the byte currently offered.
    assign cnt_inc   = {1'b0, byte_cnt_q} + 12'd1;
    assign at_min    = cnt_inc >= MIN_C;
    assign at_max    = cnt_inc == MAX_C;
    assign tx_xfer   = tx_valid && tx_ready;
    assign ifg_done  = ifg_cnt_q == IFG_W'(IFG_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) state_d = FORWARD;
            end
            FORWARD: begin
                if (tx_xfer) begin
                    if (at_max) begin
                        state_d = cur_last ? IFG : DRAIN;
                    end else if (cur_last) begin
                        state_d = at_min ? IFG : PAD;
                    end
                end
            end
            PAD: begin
                if (tx_xfer && at_min) state_d = IFG;
            end
            DRAIN: begin
                if (cur_valid && cur_last) state_d = IFG;
            end
            IFG: begin
                if (ifg_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_last   = 1'b0;
        req_ready = '0;
        busy      = state_q != IDLE;
        unique case (state_q)
            FORWARD: begin
                tx_valid            = cur_valid;
                tx_data             = cur_data;
                tx_last             = cur_valid && ((cur_last && at_min) || at_max);
                req_ready[grant_id] = tx_ready;
            end
            PAD: begin
                tx_valid = 1'b1;
                tx_last  = at_min;
            end
            DRAIN: begin
                req_ready[grant_id] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id   <= '0;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            ifg_cnt_q  <= '0;
            err_trunc  <= 1'b0;
        end else begin
            err_trunc <= (state_q == FORWARD) && tx_xfer && at_max && !cur_last;
            if (state_q == IDLE && arb_valid) begin
                grant_id   <= arb_id;
                ptr_q      <= ID_W'(wrap_inc(32'(arb_id), NUM_REQ));
                byte_cnt_q <= '0;
            end else if (tx_xfer) begin
                byte_cnt_q <= byte_cnt_q + 11'd1;
            end
            if (state_q == IFG) begin
                ifg_cnt_q <= ifg_cnt_q + IFG_W'(1);
            end else begin
                ifg_cnt_q <= '0;
            end
        end
    end

endmodule
